wb_arb2: RTL

WB_ARB2 -- requirements
Module: wb_arb2

---
 rtl/wb_arb2.sv | 112 +++++++++++
 1 files changed

// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter sharing one slave; round-robin on ties,
// locked cycles, and a strobe timeout that returns a bus error.
module wb_arb2 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_sys_i,
    input  logic        rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [4:0]  m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [4:0]  m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [4:0]  s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    state_t      state, state_d;
    logic        last_gnt, last_d;
    logic [7:0]  cnt, cnt_d;
    logic        tmo, tmo_d;
    logic        own0, own1;
    logic        o_cyc, o_stb, err;

    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);

    assign o_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
    assign o_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);

    // tmo is the registered error; an ack in the same cycle wins over it
    assign err = tmo & ~s_ack_i;

    assign s_cyc_o = o_cyc & ~tmo;
    assign s_stb_o = o_stb & ~tmo;
    assign s_we_o  = (own0 & m0_we_i) | (own1 & m1_we_i);
    assign s_adr_o = own0 ? m0_adr_i : (own1 ? m1_adr_i : 5'd0);
    assign s_dat_o = own0 ? m0_dat_i : (own1 ? m1_dat_i : 32'd0);

    assign m0_ack_o = s_ack_i & own0 & m0_stb_i;
    assign m1_ack_o = s_ack_i & own1 & m1_stb_i;
    assign m0_err_o = err & own0;
    assign m1_err_o = err & own1;
    assign m0_dat_o = own0 ? s_dat_i : 32'd0;
    assign m1_dat_o = own1 ? s_dat_i : 32'd0;

    assign gnt_o = state;

    always_comb begin
        state_d = state;
        last_d  = last_gnt;
        cnt_d   = 8'd0;
        tmo_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_d = last_gnt ? OWN0 : OWN1;
                else if (m0_cyc_i)
                    state_d = OWN0;
                else if (m1_cyc_i)
                    state_d = OWN1;
            end
            OWN0: if (!m0_cyc_i || err) state_d = IDLE;
            OWN1: if (!m1_cyc_i || err) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state == IDLE && state_d == OWN0) last_d = 1'b0;
        if (state == IDLE && state_d == OWN1) last_d = 1'b1;
        if (state != IDLE && state_d == state && o_stb && !s_ack_i)
            cnt_d = (cnt >= LIMIT) ? LIMIT : cnt + 8'd1;
        tmo_d = (cnt_d == LIMIT);
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            cnt      <= 8'd0;
            tmo      <= 1'b0;
        end else begin
            state    <= state_d;
            last_gnt <= last_d;
            cnt      <= cnt_d;
            tmo      <= tmo_d;
        end
    end

endmodule
